// File: rtl/text_term_ctrl.sv
// Character-cell terminal write sequencer: cursor, wrap, newline, backspace and ring-buffer scroll.
// Optional TAB handling is enabled by defining TEXT_TERM_TAB_EN.
module text_term_ctrl #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic [4:0]  scroll_base
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_CLEAR_ALL,
    S_IDLE,
    S_WRITE,
    S_BKSP,
`ifdef TEXT_TERM_TAB_EN
    S_TAB,
`endif
    S_CLEAR_ROW
  } state_t;

  state_t      state, state_n;
  logic        ready_n, wr_en_n, newline;
  logic [11:0] wr_addr_n;
  logic [7:0]  wr_data_n;
  logic [4:0]  row_n, base_n, clr_row, clr_row_n, cur_phys;
  logic [6:0]  col_n, clr_col, clr_col_n, bk_col;
`ifdef TEXT_TERM_TAB_EN
  logic [6:0]  tab_col;
`endif

  // Logical-to-physical row: the sum is below 2*ROWS, so one conditional subtract suffices.
  function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= 6'(ROWS))
      sum = sum - 6'(ROWS);
    return sum[4:0];
  endfunction

  function automatic logic [4:0] next_base(input logic [4:0] base);
    return (base == LAST_ROW) ? 5'd0 : base + 5'd1;
  endfunction

  assign cur_phys = phys_row(scroll_base, cursor_row);
  assign bk_col   = cursor_col - 7'd1;
`ifdef TEXT_TERM_TAB_EN
  assign tab_col  = cursor_col + 7'd1;
`endif

  always_comb begin
    state_n   = state;
    ready_n   = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    row_n     = cursor_row;
    col_n     = cursor_col;
    base_n    = scroll_base;
    clr_row_n = clr_row;
    clr_col_n = clr_col;
    newline   = 1'b0;

    case (state)
      S_CLEAR_ALL: begin
        wr_en_n   = 1'b1;
        wr_addr_n = {clr_row, clr_col};
        wr_data_n = BLANK;
        if (clr_col == LAST_COL) begin
          clr_col_n = 7'd0;
          if (clr_row == LAST_ROW) begin
            clr_row_n = 5'd0;
            state_n   = S_IDLE;
            ready_n   = 1'b1;
          end else begin
            clr_row_n = clr_row + 5'd1;
          end
        end else begin
          clr_col_n = clr_col + 7'd1;
        end
      end

      S_IDLE: begin
        ready_n = 1'b1;
        if (char_valid && char_ready) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            state_n   = S_WRITE;
            ready_n   = 1'b0;
            wr_en_n   = 1'b1;
            wr_addr_n = {cur_phys, cursor_col};
            wr_data_n = char_data;
          end else if (char_data == 8'h0A || char_data == 8'h0D) begin
            newline = 1'b1;
          end else if (char_data == 8'h08 && cursor_col != 7'd0) begin
            state_n   = S_BKSP;
            ready_n   = 1'b0;
            wr_en_n   = 1'b1;
            wr_addr_n = {cur_phys, bk_col};
            wr_data_n = BLANK;
`ifdef TEXT_TERM_TAB_EN
          end else if (char_data == 8'h09) begin
            state_n   = S_TAB;
            ready_n   = 1'b0;
            wr_en_n   = 1'b1;
            wr_addr_n = {cur_phys, cursor_col};
            wr_data_n = BLANK;
`endif
          end
        end
      end

      S_WRITE: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        if (cursor_col == LAST_COL)
          newline = 1'b1;
        else
          col_n = cursor_col + 7'd1;
      end

      S_BKSP: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        col_n   = bk_col;
      end

`ifdef TEXT_TERM_TAB_EN
      // Each TAB cycle shows the blank for the current cell; the next one is queued up here.
      S_TAB: begin
        if (cursor_col == LAST_COL) begin
          newline = 1'b1;
        end else begin
          col_n = tab_col;
          if (tab_col[2:0] == 3'd0) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else begin
            wr_en_n   = 1'b1;
            wr_addr_n = {cur_phys, tab_col};
            wr_data_n = BLANK;
          end
        end
      end
`endif

      S_CLEAR_ROW: begin
        wr_en_n   = 1'b1;
        wr_addr_n = {clr_row, clr_col};
        wr_data_n = BLANK;
        if (clr_col == LAST_COL) begin
          clr_col_n = 7'd0;
          state_n   = S_IDLE;
          ready_n   = 1'b1;
        end else begin
          clr_col_n = clr_col + 7'd1;
        end
      end

      default: state_n = S_CLEAR_ALL;
    endcase

    // The old top row becomes the new bottom row once the base advances.
    if (newline) begin
      col_n = 7'd0;
      if (cursor_row != LAST_ROW) begin
        row_n   = cursor_row + 5'd1;
        state_n = S_IDLE;
        ready_n = 1'b1;
      end else begin
        base_n    = next_base(scroll_base);
        clr_row_n = scroll_base;
        clr_col_n = 7'd0;
        state_n   = S_CLEAR_ROW;
        ready_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR_ALL;
      char_ready  <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 12'd0;
      wr_data     <= 8'd0;
      cursor_row  <= 5'd0;
      cursor_col  <= 7'd0;
      scroll_base <= 5'd0;
      clr_row     <= 5'd0;
      clr_col     <= 7'd0;
    end else begin
      state       <= state_n;
      char_ready  <= ready_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      cursor_row  <= row_n;
      cursor_col  <= col_n;
      scroll_base <= base_n;
      clr_row     <= clr_row_n;
      clr_col     <= clr_col_n;
    end
  end

endmodule
